// File: rtl/hyperbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_pkg
// Description : Shared definitions for the HyperBus responder. Includes the
//               command/address field positions, FSM states, register select
//               codes and configuration register reset values.
// Revision    : 1.0 - initial release
// ============================================================================
package hyperbus_pkg;

  // Bit positions within the 48-bit command/address word
  localparam int CA_RD_BIT     = 47;
  localparam int CA_REG_BIT    = 46;
  localparam int CA_LIN_BIT    = 45;
  localparam int CA_ROW_MSB    = 44;
  localparam int CA_ROW_LSB    = 16;
  localparam int CA_COL_W      = 3;
  localparam int CA_REGSEL_HI  = 24;
  localparam int CA_REGSEL_LO  = 0;

  // Responder transaction states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CA1   = 3'd1,
    ST_CA2   = 3'd2,
    ST_LAT   = 3'd3,
    ST_RDATA = 3'd4,
    ST_WDATA = 3'd5,
    ST_REGW  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Register space select codes, formed as {CA[24], CA[0]}
  typedef enum logic [1:0] {
    REG_ID0 = 2'b00,
    REG_ID1 = 2'b01,
    REG_CR0 = 2'b10,
    REG_CR1 = 2'b11
  } regsel_e;

  localparam logic [15:0] CR0_RESET = 16'h8F1F;
  localparam logic [15:0] CR1_RESET = 16'hFFC1;

endpackage
`default_nettype wire

// File: rtl/hyperbus_responder_mem.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_responder_mem
// Description : Single-port word RAM with synchronous, enable-gated read.
//               Read data holds when no read is issued, so a stalled burst
//               keeps its prefetched word.
// Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_responder_mem #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int MEM_WORDS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Array write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // One-cycle synchronous read, updated only when a read is issued
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/hyperbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_responder
// Description : HyperBus device-side responder (single-clock SDR model).
//               Decodes CA, applies initial latency, serves register and
//               memory reads with an RWDS strobe and accepts masked writes.
// Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_responder
  import hyperbus_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          LAT_CYCLES = 6,
  parameter int          WRAP_LEN   = 16,
  parameter logic [15:0] ID0_VAL    = 16'h0C81,
  parameter logic [15:0] ID1_VAL    = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic        ck_en,
  input  logic [15:0] dq_in,
  input  logic        rwds_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        rwds_out,
  output logic        rwds_oe,
  output logic [15:0] cr0,
  output logic        busy
);

  localparam int              CNT_W     = $clog2(2 * LAT_CYCLES);
  localparam logic [CNT_W-1:0] LAT_1X   = CNT_W'(LAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_2X   = CNT_W'(2 * LAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(WRAP_LEN - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  lat_cnt_q;
  logic [15:0]       ca_hi_q;
  logic [15:0]       ca_mid_q;
  logic              rd_q;
  logic              reg_q;
  logic              lin_q;
  regsel_e           regsel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       cr0_q;
  logic [15:0]       cr1_q;
  logic [15:0]       dq_out_q;
  logic              dq_oe_q;
  logic              rwds_out_q;
  logic              rwds_oe_q;

  logic              active_d;
  logic              dbl_d;
  logic [47:0]       ca_d;
  logic [31:0]       waddr_full_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       reg_rdata_d;
  logic              mem_we_d;
  logic              mem_re_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [15:0]       mem_rdata;
  logic              unused_bits;

  assign active_d     = !csn && ck_en;
  assign dbl_d        = cr0_q[3];
  // The final CA word is consumed straight off the bus in the CA2 cycle
  assign ca_d         = {ca_hi_q, ca_mid_q, dq_in};
  assign waddr_full_d = {ca_d[CA_ROW_MSB:CA_ROW_LSB], ca_d[CA_COL_W-1:0]};
  assign waddr_d      = waddr_full_d[ADDR_W-1:0];
  assign unused_bits  = ^{ca_d, waddr_full_d};

  // Burst address advance: full increment when linear, low bits only when wrapped
  always_comb begin
    addr_d = addr_q + ADDR_W'(1);
    if (!lin_q) begin
      addr_d = (addr_q & ~WRAP_MASK) | ((addr_q + ADDR_W'(1)) & WRAP_MASK);
    end
  end

  // Register space read mux
  always_comb begin
    reg_rdata_d = ID0_VAL;
    case (regsel_q)
      REG_ID0: reg_rdata_d = ID0_VAL;
      REG_ID1: reg_rdata_d = ID1_VAL;
      REG_CR0: reg_rdata_d = cr0_q;
      REG_CR1: reg_rdata_d = cr1_q;
      default: reg_rdata_d = ID0_VAL;
    endcase
  end

  // RAM control: first read in the last latency cycle, then prefetch the next word per data cycle
  always_comb begin
    mem_we_d   = active_d && (state_q == ST_WDATA) && !rwds_in;
    mem_re_d   = active_d && !reg_q &&
                 (((state_q == ST_LAT) && (lat_cnt_q == '0) && rd_q) ||
                  (state_q == ST_RDATA));
    mem_addr_d = (state_q == ST_RDATA) ? addr_d : addr_q;
  end

  hyperbus_responder_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we_d),
    .re_i    (mem_re_d),
    .addr_i  (mem_addr_d),
    .wdata_i (dq_in),
    .rdata_o (mem_rdata)
  );

  // Transaction FSM with registered bus outputs; csn high aborts from any state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      ca_hi_q    <= '0;
      ca_mid_q   <= '0;
      rd_q       <= 1'b0;
      reg_q      <= 1'b0;
      lin_q      <= 1'b0;
      regsel_q   <= REG_ID0;
      addr_q     <= '0;
      cr0_q      <= CR0_RESET;
      cr1_q      <= CR1_RESET;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
    end else if (csn) begin
      state_q    <= ST_IDLE;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
    end else if (ck_en) begin
      case (state_q)
        ST_IDLE: begin
          ca_hi_q    <= dq_in;
          rwds_oe_q  <= 1'b1;
          rwds_out_q <= dbl_d;
          state_q    <= ST_CA1;
        end
        ST_CA1: begin
          ca_mid_q <= dq_in;
          state_q  <= ST_CA2;
        end
        ST_CA2: begin
          rd_q       <= ca_d[CA_RD_BIT];
          reg_q      <= ca_d[CA_REG_BIT];
          lin_q      <= ca_d[CA_LIN_BIT];
          regsel_q   <= regsel_e'({ca_d[CA_REGSEL_HI], ca_d[CA_REGSEL_LO]});
          addr_q     <= waddr_d;
          rwds_oe_q  <= 1'b0;
          rwds_out_q <= 1'b0;
          if (!ca_d[CA_RD_BIT] && ca_d[CA_REG_BIT]) begin
            state_q <= ST_REGW;
          end else begin
            lat_cnt_q <= dbl_d ? LAT_2X : LAT_1X;
            state_q   <= ST_LAT;
          end
        end
        ST_LAT: begin
          if (lat_cnt_q == '0) begin
            state_q <= rd_q ? ST_RDATA : ST_WDATA;
          end else begin
            lat_cnt_q <= lat_cnt_q - CNT_W'(1);
          end
        end
        ST_RDATA: begin
          dq_out_q   <= reg_q ? reg_rdata_d : mem_rdata;
          dq_oe_q    <= 1'b1;
          rwds_oe_q  <= 1'b1;
          rwds_out_q <= 1'b1;
          addr_q     <= addr_d;
        end
        ST_WDATA: begin
          addr_q <= addr_d;
        end
        ST_REGW: begin
          if (regsel_q == REG_CR0) begin
            cr0_q <= dq_in;
          end else if (regsel_q == REG_CR1) begin
            cr1_q <= dq_in;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dq_out   = dq_out_q;
  assign dq_oe    = dq_oe_q;
  assign rwds_out = rwds_out_q;
  assign rwds_oe  = rwds_oe_q;
  assign cr0      = cr0_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyperbus_responder
// Description : Self-checking bench for hyperbus_responder with a word-array
//               and register reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hyperbus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        csn;
  logic        ck_en;
  logic [15:0] dq_in;
  logic        rwds_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        rwds_out;
  logic        rwds_oe;
  logic [15:0] cr0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_mem [1024];
  logic [15:0] m_cr0;
  logic [15:0] m_cr1;
  logic [15:0] rbuf  [64];
  logic        rwbuf [64];
  logic [15:0] wbuf  [64];
  logic        mbuf  [64];

  always #5 clk = ~clk;

  hyperbus_responder #(
    .ADDR_W     (10),
    .LAT_CYCLES (6),
    .WRAP_LEN   (16),
    .ID0_VAL    (16'h0C81),
    .ID1_VAL    (16'h0001)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .csn      (csn),
    .ck_en    (ck_en),
    .dq_in    (dq_in),
    .rwds_in  (rwds_in),
    .dq_out   (dq_out),
    .dq_oe    (dq_oe),
    .rwds_out (rwds_out),
    .rwds_oe  (rwds_oe),
    .cr0      (cr0),
    .busy     (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Build a CA word from its fields (word address for memory, regsel for registers)
  function automatic logic [47:0] mk_ca(input logic rd, input logic rg, input logic lin,
                                        input logic [9:0] a, input logic [1:0] rsel);
    logic [47:0] c;
    c = '0;
    c[47] = rd;
    c[46] = rg;
    c[45] = lin;
    c[22:16] = a[9:3];
    c[2:0] = a[2:0];
    if (rg) begin
      c[24] = rsel[1];
      c[0]  = rsel[0];
    end
    return c;
  endfunction

  // Address of the i-th beat of a burst starting at word s
  function automatic int maddr(input int s, input logic lin, input int i);
    if (lin) return (s + i) % 1024;
    return (s / 16) * 16 + ((s % 16) + i) % 16;
  endfunction

  function automatic int m_lat();
    return m_cr0[3] ? 12 : 6;
  endfunction

  function automatic logic [15:0] m_reg(input int rsel);
    case (rsel)
      0: return 16'h0C81;
      1: return 16'h0001;
      2: return m_cr0;
      default: return m_cr1;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ca(input logic [47:0] ca, output logic [1:0] oe, output logic [1:0] rw);
    csn = 1'b0;
    ck_en = 1'b1;
    dq_in = ca[47:32];
    cyc();
    oe[0] = rwds_oe;
    rw[0] = rwds_out;
    dq_in = ca[31:16];
    cyc();
    oe[1] = rwds_oe;
    rw[1] = rwds_out;
    dq_in = ca[15:0];
    cyc();
  endtask

  task automatic end_txn();
    csn = 1'b1;
    ck_en = 1'b1;
    dq_in = '0;
    rwds_in = 1'b0;
    cyc();
  endtask

  // Read burst: lat = latency cycles seen before the first word, -1 on timeout
  task automatic do_read(input logic [47:0] ca, input int n,
                         output logic [1:0] oe, output logic [1:0] rw, output int lat);
    send_ca(ca, oe, rw);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (dq_oe === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat >= 0) begin
      for (int k = 0; k < n; k++) begin
        if (k > 0) cyc();
        rbuf[k]  = dq_out;
        rwbuf[k] = rwds_out & rwds_oe;
      end
    end
    end_txn();
  endtask

  // Write burst from wbuf/mbuf; the model stores every unmasked beat
  task automatic do_write(input int s, input logic lin, input int n);
    logic [1:0] oe;
    logic [1:0] rw;
    logic [9:0] a;
    a = s[9:0];
    send_ca(mk_ca(1'b0, 1'b0, lin, a, 2'b00), oe, rw);
    repeat (m_lat()) cyc();
    for (int k = 0; k < n; k++) begin
      dq_in = wbuf[k];
      rwds_in = mbuf[k];
      cyc();
      if (!mbuf[k]) m_mem[maddr(s, lin, k)] = wbuf[k];
    end
    end_txn();
  endtask

  task automatic reg_write(input logic [1:0] rsel, input logic [15:0] data);
    logic [1:0] oe;
    logic [1:0] rw;
    send_ca(mk_ca(1'b0, 1'b1, 1'b1, 10'd0, rsel), oe, rw);
    dq_in = data;
    cyc();
    if (rsel == 2'b10) m_cr0 = data;
    if (rsel == 2'b11) m_cr1 = data;
    end_txn();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    csn = 1'b1;
    ck_en = 1'b0;
    dq_in = '0;
    rwds_in = 1'b0;
    repeat (2) cyc();
    n_tests++; if (dq_out !== 16'h0) begin n_fail++; $display("FAIL reset_dq_out got %h want 0000", dq_out); end
    n_tests++; if (dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dq_oe got %b want 0", dq_oe); end
    n_tests++; if (rwds_out !== 1'b0) begin n_fail++; $display("FAIL reset_rwds_out got %b want 0", rwds_out); end
    n_tests++; if (rwds_oe !== 1'b0) begin n_fail++; $display("FAIL reset_rwds_oe got %b want 0", rwds_oe); end
    n_tests++; if (cr0 !== 16'h8F1F) begin n_fail++; $display("FAIL reset_cr0 got %h want 8f1f", cr0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b1;
    m_cr0 = 16'h8F1F;
    m_cr1 = 16'hFFC1;
    cyc();
  endtask

  task automatic test_init_mem();
    for (int i = 0; i < 32; i++) begin
      wbuf[i] = 16'($urandom);
      mbuf[i] = 1'b0;
    end
    do_write(0, 1'b1, 32);
  endtask

  task automatic test_reg_read();
    logic [1:0] oe;
    logic [1:0] rw;
    int lat;
    for (int r = 0; r < 4; r++) begin
      do_read(mk_ca(1'b1, 1'b1, 1'b1, 10'd0, 2'(r)), 3, oe, rw, lat);
      n_tests++; if (oe !== 2'b11) begin n_fail++; $display("FAIL regrd%0d_ca_rwds_oe got %b want 11", r, oe); end
      n_tests++; if (rw !== {2{m_cr0[3]}}) begin n_fail++; $display("FAIL regrd%0d_ca_rwds got %b want %b", r, rw, {2{m_cr0[3]}}); end
      n_tests++; if (lat != m_lat()) begin n_fail++; $display("FAIL regrd%0d_latency got %0d want %0d", r, lat, m_lat()); end
      for (int k = 0; k < 3; k++) begin
        n_tests++; if (rbuf[k] !== m_reg(r) || rwbuf[k] !== 1'b1) begin
          n_fail++; $display("FAIL regrd%0d_word%0d got %h/%b want %h/1", r, k, rbuf[k], rwbuf[k], m_reg(r));
        end
      end
    end
  endtask

  task automatic test_reg_write();
    logic [1:0] oe;
    logic [1:0] rw;
    int lat;
    logic [15:0] v;
    reg_write(2'b10, 16'h8F17);
    n_tests++; if (cr0 !== 16'h8F17) begin n_fail++; $display("FAIL regwr_cr0 got %h want 8f17", cr0); end
    do_read(mk_ca(1'b1, 1'b1, 1'b1, 10'd0, 2'b00), 2, oe, rw, lat);
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL regwr_lat1x got %0d want 6", lat); end
    n_tests++; if (rw !== 2'b00 || oe !== 2'b11) begin n_fail++; $display("FAIL regwr_ca_rwds got %b/%b want 00/11", rw, oe); end
    n_tests++; if (rbuf[0] !== 16'h0C81) begin n_fail++; $display("FAIL regwr_id0 got %h want 0c81", rbuf[0]); end
    v = 16'($urandom);
    reg_write(2'b00, v);
    do_read(mk_ca(1'b1, 1'b1, 1'b1, 10'd0, 2'b00), 1, oe, rw, lat);
    n_tests++; if (rbuf[0] !== 16'h0C81) begin n_fail++; $display("FAIL regwr_id0_readonly got %h want 0c81", rbuf[0]); end
    v = 16'($urandom);
    reg_write(2'b11, v);
    do_read(mk_ca(1'b1, 1'b1, 1'b1, 10'd0, 2'b11), 1, oe, rw, lat);
    n_tests++; if (rbuf[0] !== m_cr1) begin n_fail++; $display("FAIL regwr_cr1 got %h want %h", rbuf[0], m_cr1); end
  endtask

  task automatic test_linear_masked();
    logic [1:0] oe;
    logic [1:0] rw;
    int lat;
    logic [15:0] old10;
    old10 = m_mem[10];
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    mbuf[0] = 1'b0; mbuf[1] = 1'b0; mbuf[2] = 1'b1; mbuf[3] = 1'b0;
    do_write(8, 1'b1, 4);
    do_read(mk_ca(1'b1, 1'b0, 1'b1, 10'd8, 2'b00), 4, oe, rw, lat);
    n_tests++; if (lat != m_lat()) begin n_fail++; $display("FAIL lin_latency got %0d want %0d", lat, m_lat()); end
    n_tests++; if (rbuf[0] !== 16'h1111 || rbuf[1] !== 16'h2222) begin n_fail++; $display("FAIL lin_w01 got %h %h want 1111 2222", rbuf[0], rbuf[1]); end
    n_tests++; if (rbuf[2] !== old10) begin n_fail++; $display("FAIL lin_masked got %h want %h", rbuf[2], old10); end
    n_tests++; if (rbuf[3] !== 16'h4444) begin n_fail++; $display("FAIL lin_w3 got %h want 4444", rbuf[3]); end
  endtask

  task automatic test_wrap_random();
    logic [1:0] oe;
    logic [1:0] rw;
    int lat;
    int s;
    int n;
    logic lin;
    logic [9:0] a;
    do_read(mk_ca(1'b1, 1'b0, 1'b0, 10'd14, 2'b00), 4, oe, rw, lat);
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (rbuf[k] !== m_mem[maddr(14, 1'b0, k)]) begin
        n_fail++; $display("FAIL wrap14_word%0d got %h want %h", k, rbuf[k], m_mem[maddr(14, 1'b0, k)]);
      end
    end
    for (int it = 0; it < 6; it++) begin
      s   = int'($urandom_range(0, 15));
      lin = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 16));
      for (int k = 0; k < n; k++) begin
        wbuf[k] = 16'($urandom);
        mbuf[k] = ($urandom_range(0, 3) == 0);
      end
      do_write(s, lin, n);
      a = s[9:0];
      do_read(mk_ca(1'b1, 1'b0, lin, a, 2'b00), n, oe, rw, lat);
      n_tests++; if (lat != m_lat()) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, m_lat()); end
      for (int k = 0; k < n; k++) begin
        n_tests++; if (rbuf[k] !== m_mem[maddr(s, lin, k)]) begin
          n_fail++; $display("FAIL rand%0d_word%0d s=%0d lin=%b got %h want %h", it, k, s, lin, rbuf[k], m_mem[maddr(s, lin, k)]);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [1:0] oe;
    logic [1:0] rw;
    int lat;
    send_ca(mk_ca(1'b1, 1'b0, 1'b1, 10'd20, 2'b00), oe, rw);
    repeat (3) cyc();
    csn = 1'b1;
    cyc();
    n_tests++; if (busy !== 1'b0 || dq_oe !== 1'b0 || rwds_oe !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got busy=%b dq_oe=%b rwds_oe=%b want 0 0 0", busy, dq_oe, rwds_oe);
    end
    do_read(mk_ca(1'b1, 1'b0, 1'b1, 10'd20, 2'b00), 4, oe, rw, lat);
    n_tests++; if (lat != m_lat()) begin n_fail++; $display("FAIL abort_next_latency got %0d want %0d", lat, m_lat()); end
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (rbuf[k] !== m_mem[20 + k]) begin n_fail++; $display("FAIL abort_next_word%0d got %h want %h", k, rbuf[k], m_mem[20 + k]); end
    end
    wbuf[0] = 16'($urandom); wbuf[1] = 16'($urandom);
    mbuf[0] = 1'b0; mbuf[1] = 1'b0;
    do_write(24, 1'b1, 2);
    do_read(mk_ca(1'b1, 1'b0, 1'b1, 10'd24, 2'b00), 4, oe, rw, lat);
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (rbuf[k] !== m_mem[24 + k]) begin n_fail++; $display("FAIL partial_write_word%0d got %h want %h", k, rbuf[k], m_mem[24 + k]); end
    end
  endtask

  task automatic test_stall();
    logic [1:0] oe;
    logic [1:0] rw;
    int lat;
    send_ca(mk_ca(1'b1, 1'b0, 1'b1, 10'd0, 2'b00), oe, rw);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (dq_oe === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_tests++; if (lat != m_lat()) begin n_fail++; $display("FAIL stall_latency got %0d want %0d", lat, m_lat()); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      n_tests++; if (dq_out !== m_mem[k]) begin n_fail++; $display("FAIL stall_pre_word%0d got %h want %h", k, dq_out, m_mem[k]); end
    end
    ck_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      n_tests++; if (dq_out !== m_mem[2] || dq_oe !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold%0d got %h/%b want %h/1", j, dq_out, dq_oe, m_mem[2]);
      end
    end
    ck_en = 1'b1;
    for (int k = 3; k < 6; k++) begin
      cyc();
      n_tests++; if (dq_out !== m_mem[k]) begin n_fail++; $display("FAIL stall_post_word%0d got %h want %h", k, dq_out, m_mem[k]); end
    end
    end_txn();
  endtask

  initial begin
    test_reset();
    test_init_mem();
    test_reg_read();
    test_reg_write();
    test_linear_masked();
    test_wrap_random();
    test_abort();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hyperbus_responder.md
Name: hyperbus_responder

Overview:
- HyperBus device-side responder: the memory/register end of the bus driven by our HyperRAM controller.
- Uses the same single-clock, 16-bit-per-cycle SDR abstraction of the bus.
- Decodes the 48-bit command/address (CA), inserts initial latency, returns read data with an RWDS strobe, and accepts masked write data into an internal word array.
- Used as a synthesizable loopback target for controller bring-up on FPGA and as the bench responder.

Parameters:
- ADDR_W, 10, word-address width of internal array (MEM_WORDS = 2**ADDR_W).
- LAT_CYCLES, 6, initial latency in active cycles (doubled when 2x latency is in effect).
- WRAP_LEN, 16, wrapped-burst group length in words (power of 2).
- ID0_VAL, 16'h0C81, ID register 0 contents.
- ID1_VAL, 16'h0001, ID register 1 contents.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-low reset
- csn  in  1  chip select from controller, active low
- ck_en  in  1  bus clock enable (controller oe_clk); a cycle is "active" when csn=0 and ck_en=1
- dq_in  in  16  controller-driven DQ word
- rwds_in  in  1  controller-driven RWDS: write mask, 1 = word masked
- dq_out  out  16  responder-driven DQ word
- dq_oe  out  1  DQ output enable
- rwds_out  out  1  latency indicator during CA; data-valid strobe during read data
- rwds_oe  out  1  RWDS output enable
- cr0  out  16  current CR0 (debug)
- busy  out  1  1 while not in IDLE

Behaviour:
- Reset (rst=0 at posedge): state IDLE; dq_out=0, dq_oe=0, rwds_out=0, rwds_oe=0, busy=0; CR0=16'h8F1F, CR1=16'hFFC1. Array contents are not reset.
- csn=1 at any posedge forces IDLE next cycle and deasserts all enables. This is the abort path, valid mid-CA, mid-latency or mid-burst; a partial write keeps the words already written.
- Only active cycles advance the FSM. Inactive cycles with csn=0 hold all state and outputs.
- IDLE: the first active cycle captures CA[47:32] -> CA1.
- CA1: capture CA[31:16] -> CA2.
- During CA0..CA2: rwds_oe=1, rwds_out=dbl, where dbl=CR0[3].
- CA2: capture CA[15:0]. Decode:
  - rd=CA[47], reg=CA[46], linear=CA[45]
  - waddr={CA[44:16],CA[2:0]} truncated to ADDR_W
  - regsel={CA[24],CA[0]}: 00=ID0, 01=ID1, 10=CR0, 11=CR1
- CA2 transitions:
  - register write (rd=0, reg=1) -> REGW, zero latency
  - otherwise -> LAT, counter = (dbl ? 2*LAT_CYCLES : LAT_CYCLES) - 1
- LAT: decrement per active cycle. At 0 -> RDATA if rd, else WDATA. For memory reads, the RAM read for waddr is issued in the LAT cycle where the counter is 0.
- RDATA: each active cycle drives one word with dq_oe=1, rwds_oe=1, rwds_out=1.
  - Memory reads: prefetch next address each cycle.
  - Register reads: the selected register repeats every word.
  - Output is registered: word n appears the cycle after its active cycle; no bubbles while ck_en stays high.
- WDATA: each active cycle writes dq_in to the current address unless rwds_in=1 (masked). Address then advances.
- Address advance:
  - linear: waddr+1 modulo MEM_WORDS
  - wrapped: low log2(WRAP_LEN) bits increment modulo WRAP_LEN, upper bits fixed
- REGW: first active cycle writes dq_in to CR0 (regsel=10) or CR1 (11). ID writes are ignored. Then -> DONE.
- DONE: ignore bus until csn=1.
- A CR0 write changes dbl starting with the next transaction.
- A memory write with rd=0, reg=0 never drives DQ. rwds_oe=0 after CA2.

Decomposition:
- Shared package hyperbus_pkg:
  - CA field bit positions
  - state enum (IDLE, CA1, CA2, LAT, RDATA, WDATA, REGW, DONE)
  - register select codes
  - CR0/CR1 reset constants
- Sub-module hyperbus_responder_mem: single-port 16-bit RAM, synchronous read, 1-cycle latency, write enable.

Test Plan:
- Reset: rst=0 for 2 cycles -> all outputs 0, cr0=16'h8F1F, busy=0.
- Reg read CA 48'hC000_0000_0000, dbl=1 -> rwds_out=1 during CA, 12 latency cycles, dq_out=16'h0C81 with rwds_out=1. Repeat with CA 48'hC000_0100_0000 -> 16'h8F1F.
- Reg write CA 48'h6000_0100_0000 data 16'h8F17 -> cr0=16'h8F17. A following read has 6 latency cycles and rwds_out=0 during CA.
- Linear write of 4 words 1111,2222,3333,4444 at word 8, rwds_in=1 on word 3, then linear read of 4 at word 8 -> 1111,2222,old,4444.
- Wrapped read of 4 starting word 14 (WRAP_LEN=16) -> addresses 14,15,0,1 returned.
- csn deasserted mid-latency, then a new read -> aborted transaction has no effect, new read completes normally; ck_en low for 3 cycles mid-burst -> data holds, no words skipped.
